dcm_ctrl: RTL and testbench
===========================

DCM_CTRL -- requirements
Module: dcm_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: cycles in COOLDOWN after a confirmed change.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000: cycles in WAIT_ACK before a retry is declared.
REQ-003 SHALL have parameter MAX_RETRY, default 3: update attempts allowed before FAULT.
REQ-004 SHALL have port clk, input, 1 bit: 100 MHz system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port inc, input, 1 bit: level request to step the slow-clock selection up.
REQ-007 SHALL have port dec, input, 1 bit: level request to step the slow-clock selection down.
REQ-008 SHALL have port load, input, 1 bit: level request to jump to load_val.
REQ-009 SHALL have port load_val, input, 3 bits: absolute target selection.
REQ-010 SHALL have port prog_fb, input, 3 bits: selection the divider reports as active.
REQ-011 SHALL have port update, output, 1 bit: one-cycle command pulse to the divider.
REQ-012 SHALL have port prog_sel, output, 3 bits: selection driven to the divider's prog_in.
REQ-013 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.
REQ-014 SHALL have port err, output, 1 bit: 1 while in FAULT.

Function
REQ-015 SHALL detect rising edges of inc, dec and load internally; a held level SHALL produce exactly one request.
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_ACK, COOLDOWN and FAULT.
REQ-017 In IDLE, request priority SHALL be load, then inc, then dec.
REQ-018 A same-cycle inc and dec edge without load SHALL be ignored.
REQ-019 An inc edge with target 7 or a dec edge with target 0 SHALL saturate: no state change and no update pulse.
REQ-020 A valid request SHALL set target to target+1, target-1 or load_val; prog_sel SHALL follow in the same cycle; the next state SHALL be ISSUE.
REQ-021 A load with load_val equal to target SHALL still run a full ISSUE sequence.
REQ-022 ISSUE SHALL assert update for exactly one cycle, clear the timeout counter and go to WAIT_ACK.
REQ-023 prog_sel SHALL stay stable from ISSUE until control returns to IDLE or reaches FAULT.
REQ-024 In WAIT_ACK, prog_fb equal to target SHALL clear the retry counter and go to COOLDOWN.
REQ-025 If prog_fb does not match within ACK_TIMEOUT cycles, the retry counter SHALL increment.
REQ-026 After a timeout, the block SHALL re-enter ISSUE while retries are below MAX_RETRY, and go to FAULT otherwise.
REQ-027 COOLDOWN SHALL last exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-028 Edges of inc, dec or load arriving while busy SHALL be dropped, not queued.
REQ-029 FAULT SHALL hold err=1 and ignore inc and dec.
REQ-030 A load edge in FAULT SHALL clear err and the retry counter, set target to load_val and go to ISSUE.
REQ-031 Counters SHALL be sized with $clog2 of their parameter and SHALL never wrap.
REQ-032 Latency from a request edge to the update pulse SHALL be 2 cycles: edge register, then ISSUE.

Reset
REQ-033 rst SHALL force IDLE, target=0, prog_sel=0, update=0, busy=0 and err=0, and SHALL clear all counters and edge registers asynchronously.
REQ-034 Reset asserted mid-sequence SHALL abort the sequence with no further update pulse.

Structure
REQ-035 State encoding, PROG_MIN=0 and PROG_MAX=7 SHALL live in the shared package dcm_pkg.
REQ-036 Edge detection SHALL use one edge_detector sub-module instance per input: inc, dec and load.

Verification
REQ-037 From reset, 3 inc pulses with prog_fb tracking prog_sel: 3 update pulses; prog_sel=1, 2, 3; busy drops HOLD_CYCLES after each match.
REQ-038 load_val=7 then 2 inc pulses: one update, prog_sel=7; the inc pulses produce no update and busy stays 0.
REQ-039 prog_fb held at 0 after a load of 5: 3 update pulses spaced ACK_TIMEOUT+1 cycles apart, then err=1; a later inc is ignored; a load of 0 clears err.
REQ-040 inc and dec asserted together in IDLE: no update; prog_sel unchanged.
REQ-041 inc held high for 50 cycles: exactly one update pulse.
REQ-042 rst asserted 5 cycles into WAIT_ACK: outputs return to 0 immediately and no update pulse follows.

Source files
------------

// File: rtl/dcm_pkg.sv
// Shared definitions for the slow-clock divider controller: FSM states and
// the legal range of the 3-bit divider selection.
package dcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_COOLDOWN,
    ST_FAULT
  } state_t;

  localparam logic [2:0] PROG_MIN = 3'd0;
  localparam logic [2:0] PROG_MAX = 3'd7;

endpackage

// File: rtl/edge_detector.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition,
// so a level held for many cycles yields a single request.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/dcm_ctrl.sv
// Divider selection controller: turns inc/dec/load requests into a handshaked
// update of the divider, with ack timeout, bounded retries and a fault state.
module dcm_ctrl
  import dcm_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int ACK_TIMEOUT = 1000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic [2:0] prog_fb,
  output logic       update,
  output logic [2:0] prog_sel,
  output logic       busy,
  output logic       err
);

  localparam int TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t             state;
  logic [2:0]         target;
  logic [TO_W-1:0]    timeout_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_inc;

  logic       inc_edge;
  logic       dec_edge;
  logic       load_edge;
  logic       req_valid;
  logic [2:0] req_target;

  edge_detector u_inc_edge  (.clk(clk), .rst(rst), .level(inc),  .pulse(inc_edge));
  edge_detector u_dec_edge  (.clk(clk), .rst(rst), .level(dec),  .pulse(dec_edge));
  edge_detector u_load_edge (.clk(clk), .rst(rst), .level(load), .pulse(load_edge));

  assign prog_sel  = target;
  assign retry_inc = retry_cnt + RETRY_W'(1);

  // Arbitrate IDLE requests: load wins, opposing inc/dec cancel, ends saturate.
  always_comb begin
    req_valid  = 1'b0;
    req_target = target;
    if (load_edge) begin
      req_valid  = 1'b1;
      req_target = load_val;
    end else if (inc_edge && !dec_edge) begin
      if (target != PROG_MAX) begin
        req_valid  = 1'b1;
        req_target = target + 3'd1;
      end
    end else if (dec_edge && !inc_edge) begin
      if (target != PROG_MIN) begin
        req_valid  = 1'b1;
        req_target = target - 3'd1;
      end
    end
  end

  // update is raised on every transition into ISSUE and dropped by default,
  // so it is high for exactly the one cycle spent in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      target      <= PROG_MIN;
      update      <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      timeout_cnt <= '0;
      hold_cnt    <= '0;
      retry_cnt   <= '0;
    end else begin
      update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            target <= req_target;
            update <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          timeout_cnt <= '0;
          state       <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (prog_fb == target) begin
            retry_cnt <= '0;
            hold_cnt  <= '0;
            state     <= ST_COOLDOWN;
          end else if (timeout_cnt == TO_LAST) begin
            retry_cnt <= retry_inc;
            if (retry_inc < RETRY_MAX) begin
              update <= 1'b1;
              state  <= ST_ISSUE;
            end else begin
              err   <= 1'b1;
              state <= ST_FAULT;
            end
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end

        ST_COOLDOWN: begin
          if (hold_cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_FAULT: begin
          if (load_edge) begin
            err       <= 1'b0;
            retry_cnt <= '0;
            target    <= load_val;
            update    <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_ctrl.sv
// Directed self-checking bench for dcm_ctrl with shortened timing parameters
// so retry and cooldown windows stay a few dozen cycles long.
module tb_dcm_ctrl;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int RTRY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic       dec;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] prog_fb;
  logic       update;
  logic [2:0] prog_sel;
  logic       busy;
  logic       err;

  logic       track;
  logic [2:0] fb_force;
  int         checks = 0;
  int         errors = 0;
  int         upd_count = 0;
  int         u0;

  assign prog_fb = track ? prog_sel : fb_force;

  dcm_ctrl #(.HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO), .MAX_RETRY(RTRY)) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .prog_fb(prog_fb), .update(update),
    .prog_sel(prog_sel), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Counts update pulses mid-cycle, away from the edge that changes them.
  always @(negedge clk) begin
    if (update === 1'b1) upd_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses one request input (0=inc, 1=dec, 2=load) high for one cycle.
  task automatic applyStimulus(input int which);
    case (which)
      0: inc = 1'b1;
      1: dec = 1'b1;
      default: load = 1'b1;
    endcase
    step(1);
    inc = 1'b0; dec = 1'b0; load = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && busy; i++) step(1);
    checkOutput("idle_reached", busy, 0);
  endtask

  initial begin
    rst = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0;
    load_val = 3'd0; track = 1'b1; fb_force = 3'd0;
    step(3);
    checkOutput("rst_prog_sel", prog_sel, 0);
    checkOutput("rst_update", update, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    rst = 1'b0;
    step(2);

    // Three tracked increments with exact update/busy timing.
    u0 = upd_count;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0);
      step(1);
      checkOutput("inc_update", update, 1);
      checkOutput("inc_prog_sel", prog_sel, k);
      step(5);
      checkOutput("cooldown_busy", busy, 1);
      step(1);
      checkOutput("cooldown_done", busy, 0);
    end
    checkOutput("inc_upd_count", upd_count - u0, 3);

    // Load 7, then saturating increments.
    load_val = 3'd7;
    applyStimulus(2);
    step(1);
    checkOutput("load7_update", update, 1);
    checkOutput("load7_prog_sel", prog_sel, 7);
    waitIdle();
    u0 = upd_count;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0);
      step(1);
      checkOutput("sat_busy", busy, 0);
    end
    step(3);
    checkOutput("sat_upd_count", upd_count - u0, 0);
    checkOutput("sat_prog_sel", prog_sel, 7);

    // Simultaneous inc and dec are ignored.
    u0 = upd_count;
    inc = 1'b1; dec = 1'b1;
    step(1);
    inc = 1'b0; dec = 1'b0;
    step(4);
    checkOutput("incdec_upd_count", upd_count - u0, 0);
    checkOutput("incdec_prog_sel", prog_sel, 7);
    checkOutput("incdec_busy", busy, 0);

    // Step down once, then a held inc yields one update.
    applyStimulus(1);
    step(1);
    checkOutput("dec_update", update, 1);
    checkOutput("dec_prog_sel", prog_sel, 6);
    waitIdle();
    u0 = upd_count;
    inc = 1'b1;
    step(50);
    inc = 1'b0;
    step(2);
    checkOutput("held_upd_count", upd_count - u0, 1);
    checkOutput("held_prog_sel", prog_sel, 7);

    // No ack after load 5: retries spaced TMO+1 apart, then FAULT.
    track = 1'b0; fb_force = 3'd0;
    load_val = 3'd5;
    u0 = upd_count;
    applyStimulus(2);
    step(1);
    checkOutput("retry1_update", update, 1);
    checkOutput("retry_prog_sel", prog_sel, 5);
    step(TMO);
    checkOutput("retry_gap_update", update, 0);
    step(1);
    checkOutput("retry2_update", update, 1);
    step(TMO + 1);
    checkOutput("retry3_update", update, 1);
    checkOutput("retry3_prog_sel", prog_sel, 5);
    step(TMO);
    checkOutput("pre_fault_err", err, 0);
    step(1);
    checkOutput("fault_err", err, 1);
    checkOutput("fault_busy", busy, 1);
    checkOutput("retry_upd_count", upd_count - u0, 3);
    u0 = upd_count;
    applyStimulus(0);
    step(3);
    checkOutput("fault_inc_err", err, 1);
    checkOutput("fault_inc_upd", upd_count - u0, 0);
    load_val = 3'd0;
    applyStimulus(2);
    step(1);
    checkOutput("fault_load_err", err, 0);
    checkOutput("fault_load_update", update, 1);
    checkOutput("fault_load_prog_sel", prog_sel, 0);
    waitIdle();

    // Dec at 0 saturates; reload of the same value still issues.
    u0 = upd_count;
    applyStimulus(1);
    step(3);
    checkOutput("dec0_upd_count", upd_count - u0, 0);
    track = 1'b1;
    applyStimulus(2);
    step(1);
    checkOutput("same_load_update", update, 1);
    waitIdle();

    // Requests while busy are dropped.
    u0 = upd_count;
    applyStimulus(0);
    step(1);
    applyStimulus(0);
    waitIdle();
    step(3);
    checkOutput("drop_upd_count", upd_count - u0, 1);
    checkOutput("drop_prog_sel", prog_sel, 1);

    // Reset five cycles into WAIT_ACK aborts the sequence.
    track = 1'b0; fb_force = 3'd0;
    applyStimulus(0);
    step(1);
    checkOutput("abort_update", update, 1);
    step(5);
    u0 = upd_count;
    rst = 1'b1;
    #1;
    checkOutput("abort_prog_sel", prog_sel, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_err", err, 0);
    step(2);
    rst = 1'b0;
    step(3 * TMO);
    checkOutput("abort_upd_count", upd_count - u0, 0);
    checkOutput("abort_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
